// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared widths, defaults and pointer-width helper for sync_fifo_param
package sync_fifo_pkg;

    function automatic int ptr_w(input int depth_log2);
        return depth_log2 + 1;
    endfunction

    localparam int WIDTH_DEF      = 8;
    localparam int DEPTH_LOG2_DEF = 3;
    localparam int AF_THRESH_DEF  = 6;
    localparam int AE_THRESH_DEF  = 1;
    localparam int PTR_W_DEF      = ptr_w(DEPTH_LOG2_DEF);

    typedef logic [PTR_W_DEF-1:0] ptr_def_t;
    typedef logic [WIDTH_DEF-1:0] data_def_t;

endpackage

// File: rtl/fifo_dp_mem.sv
// rtl/fifo_dp_mem.sv - simple dual-port storage, one write port, one registered read port
module fifo_dp_mem #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wr_en,
    input  logic [DEPTH_LOG2-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]      i_wr_data,
    input  logic                  i_rd_en,
    input  logic [DEPTH_LOG2-1:0] i_rd_addr,
    output logic [WIDTH-1:0]      o_rd_data
);

    logic [WIDTH-1:0] r_mem [2**DEPTH_LOG2];
    logic [WIDTH-1:0] r_rd_data;

    // Array is deliberately unreset; only the output register has a defined reset value.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock FIFO with count, threshold flags; SYNC_FIFO_ERR_EN adds sticky overflow/underflow
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int AF_THRESH  = AF_THRESH_DEF,
    parameter int AE_THRESH  = AE_THRESH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
`ifdef SYNC_FIFO_ERR_EN
    input  logic                  clr_err,
    output logic                  overflow,
    output logic                  underflow,
`endif
    output logic [WIDTH-1:0]      rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int PW = ptr_w(DEPTH_LOG2);
    typedef logic [PW-1:0] ptr_t;
    localparam ptr_t AF_T = ptr_t'(AF_THRESH);
    localparam ptr_t AE_T = ptr_t'(AE_THRESH);

    ptr_t r_wr_ptr;
    ptr_t r_rd_ptr;
    logic r_rd_valid;
    logic w_wr_acc;
    logic w_rd_acc;
    ptr_t w_count;

    // Status is a pure function of the registered pointers.
    assign empty        = (r_wr_ptr == r_rd_ptr);
    assign full         = (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]) &&
                          (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]);
    assign w_count      = r_wr_ptr - r_rd_ptr;
    assign count        = w_count;
    assign almost_full  = (w_count >= AF_T);
    assign almost_empty = (w_count <= AE_T);

    assign w_wr_acc = wr_en && !full;
    assign w_rd_acc = rd_en && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + ptr_t'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + ptr_t'(1);
            end
            r_rd_valid <= w_rd_acc;
        end
    end

    assign rd_valid = r_rd_valid;

    fifo_dp_mem #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr[DEPTH_LOG2-1:0]),
        .i_wr_data (wr_data),
        .i_rd_en   (w_rd_acc),
        .i_rd_addr (r_rd_ptr[DEPTH_LOG2-1:0]),
        .o_rd_data (rd_data)
    );

`ifdef SYNC_FIFO_ERR_EN
    logic r_overflow;
    logic r_underflow;

    // A new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (rd_en && empty) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - randomized and directed bench for sync_fifo_param against a queue model
module tb_sync_fifo_param;

    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 1;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
`ifdef SYNC_FIFO_ERR_EN
    logic       clr_err;
    logic       overflow;
    logic       underflow;
    logic       m_ovf;
    logic       m_udf;
`endif

    int n_vec;
    int n_err;

    logic [7:0] q[$];
    logic [7:0] m_rd_data;
    logic       m_rd_valid;

    sync_fifo_param dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
`ifdef SYNC_FIFO_ERR_EN
        .clr_err      (clr_err),
        .overflow     (overflow),
        .underflow    (underflow),
`endif
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string ctx);
        chk({ctx, ":count"},        32'(count),        32'(q.size()));
        chk({ctx, ":full"},         32'(full),         32'(q.size() == DEPTH));
        chk({ctx, ":empty"},        32'(empty),        32'(q.size() == 0));
        chk({ctx, ":almost_full"},  32'(almost_full),  32'(q.size() >= AF));
        chk({ctx, ":almost_empty"}, 32'(almost_empty), 32'(q.size() <= AE));
        chk({ctx, ":rd_valid"},     32'(rd_valid),     32'(m_rd_valid));
        chk({ctx, ":rd_data"},      32'(rd_data),      32'(m_rd_data));
`ifdef SYNC_FIFO_ERR_EN
        chk({ctx, ":overflow"},     32'(overflow),     32'(m_ovf));
        chk({ctx, ":underflow"},    32'(underflow),    32'(m_udf));
`endif
    endtask

    task automatic model_reset();
        q.delete();
        m_rd_data  = '0;
        m_rd_valid = 1'b0;
`ifdef SYNC_FIFO_ERR_EN
        m_ovf = 1'b0;
        m_udf = 1'b0;
`endif
    endtask

    // One clock: drive at negedge, advance the model, check just after the posedge.
    task automatic step(input string ctx, input logic wr, input logic [7:0] d, input logic rd, input logic clr);
        bit was_full;
        bit was_empty;
        @(negedge clk);
        wr_en   = wr;
        wr_data = d;
        rd_en   = rd;
`ifdef SYNC_FIFO_ERR_EN
        clr_err = clr;
`endif
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        if (rd && !was_empty) begin
            m_rd_data  = q.pop_front();
            m_rd_valid = 1'b1;
        end else begin
            m_rd_valid = 1'b0;
        end
        if (wr && !was_full) q.push_back(d);
`ifdef SYNC_FIFO_ERR_EN
        if (wr && was_full) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
        if (rd && was_empty) m_udf = 1'b1; else if (clr) m_udf = 1'b0;
`else
        if (clr) m_rd_valid = m_rd_valid;
`endif
        @(posedge clk);
        #1;
        chk_all(ctx);
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        rd_en   = 1'b0;
`ifdef SYNC_FIFO_ERR_EN
        clr_err = 1'b0;
`endif
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_all("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all("after_reset");

        for (int i = 0; i < 8; i++) step("fill", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        step("write_when_full", 1'b1, 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain_last_word", 32'(rd_data), 32'h17);
        step("read_when_empty", 1'b0, 8'h00, 1'b1, 1'b0);
        step("clear_err", 1'b0, 8'h00, 1'b0, 1'b1);

        for (int i = 0; i < 3; i++) step("wrap_prime", 1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step("wrap_rw", 1'b1, 8'(i), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step("wrap_drain", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("wrap_last_word", 32'(rd_data), 32'h13);

        for (int i = 0; i < 8; i++) step("refill", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        step("full_rw", 1'b1, 8'hEE, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step("drain2", 1'b0, 8'h00, 1'b1, 1'b0);
        step("empty_rw", 1'b1, 8'h5A, 1'b1, 1'b0);
        step("empty_rw_next", 1'b0, 8'h00, 1'b1, 1'b1);

        for (int i = 0; i < 400; i++) begin
            step("random", 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0));
        end

        while (q.size() != 0) step("pre_rst_drain", 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step("pre_rst_fill", 1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        step("pre_rst_ovf", 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        wr_en = 1'b1;
        rd_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_all("async_reset");
        wr_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step("post_rst_fill", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        step("post_rst_read", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_rst_first_word", 32'(rd_data), 32'hC0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO; next generation of the team's basic FIFO. Provides true full/empty detection and an occupancy count. Also provides programmable almost-full/almost-empty flags and a registered read port with a valid strobe. Sits between producer and consumer datapaths in the same clock domain.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH_LOG2, 3, log2 of storage depth; DEPTH = 2**DEPTH_LOG2 entries (>=1)
AF_THRESH, 6, almost_full asserted when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 1, almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
wr_en  in  1  write request
wr_data  in  WIDTH  write data
rd_en  in  1  read request
rd_data  out  WIDTH  registered read data
rd_valid  out  1  rd_data holds a newly popped word this cycle
full  out  1  DEPTH entries stored
empty  out  1  0 entries stored
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  DEPTH_LOG2+1  current occupancy, 0..DEPTH

Behaviour:
- Interface: clock clk; reset rst_n, asynchronous, active-low.
- Reset values: pointers 0, count 0, rd_data 0, rd_valid 0, empty 1, full 0, almost_full 0 (AF_THRESH>=1), almost_empty 1.
- Storage array is not reset; contents are undefined until written.
- Pointers: wr_ptr and rd_ptr are each DEPTH_LOG2+1 bits. Low bits address memory; MSB is a wrap bit. Pointers increment modulo 2**(DEPTH_LOG2+1), so wrap is natural and there is no explicit clear.
- empty = (wr_ptr == rd_ptr).
- full = (address bits equal) && (wrap bits differ).
- count = wr_ptr - rd_ptr, unsigned, width DEPTH_LOG2+1.
- All status outputs are derived combinationally from registered pointers only. No combinational path from wr_en/rd_en to any status output.
- Write accepted iff wr_en && !full. On acceptance, mem[wr_ptr addr] <= wr_data and wr_ptr increments.
- Write while full is dropped: no state change.
- Read accepted iff rd_en && !empty. On acceptance, rd_data <= mem[rd_ptr addr], rd_ptr increments, and rd_valid = 1 on the next cycle.
- Read latency is 1 cycle.
- If no read is accepted: rd_valid <= 0 and rd_data holds its previous value (not zeroed).
- Read while empty is ignored: rd_valid 0.
- Simultaneous accepted read and write: both pointers advance and count is unchanged.
- When full, rd_en && wr_en: the read is accepted and the write is rejected; full deasserts the next cycle.
- When empty, rd_en && wr_en: the write is accepted and the read is rejected. No write-to-read bypass; data is readable the cycle after it is written.
- rst_n asserted mid-operation: all outputs go immediately to reset values and stored data is discarded logically.

Optional Feature:
Macro SYNC_FIFO_ERR_EN.
- Defined: adds input clr_err (1) and outputs overflow (1) and underflow (1).
- overflow is a sticky flag set the cycle after wr_en && full. underflow is a sticky flag set the cycle after rd_en && empty.
- Both flags are cleared by clr_err (synchronous) or by reset. If set and clr_err occur in the same cycle, set wins.
- Not defined: ports and logic are absent; dropped accesses are silent.

Decomposition:
- Package sync_fifo_pkg holds:
  - function ptr_w(depth_log2) returning depth_log2+1
  - typedef templates for pointer/count widths
  - localparam defaults
- One sub-module: fifo_dp_mem, a simple dual-port array (one write port, one registered read port with read enable), parametrised by WIDTH and DEPTH_LOG2.
- Pointer, flag and error logic stay in the top module.

Test Plan:
Defaults (WIDTH=8, depth 8, AF=6, AE=1).
1. Reset check: after rst_n release, empty=1, full=0, count=0, almost_empty=1, rd_valid=0, rd_data=0.
2. Fill and drain: write 0x10..0x17 → full=1 and count=8 after the 8th write. A 9th write of 0xFF is dropped. Reading 8 words returns 0x10..0x17 in order, each with rd_valid one cycle after rd_en; empty=1 at the end.
3. Thresholds: at count 5→6, almost_full rises; at count 2→1, almost_empty rises; both fall on the reverse transitions.
4. Wrap-around: run 20 write/read cycles at count 3 with data 0x00..0x13 → pointers wrap past 16, count stays 3, and read data is in order.
5. Simultaneous events:
   - At full with rd_en=wr_en=1: count goes to 7 and the written word is lost.
   - At empty with both asserted: count goes to 1 and rd_valid=0.
6. SYNC_FIFO_ERR_EN: write while full → overflow=1 until clr_err. Read while empty → underflow=1. Asserting rst_n mid-burst at count 4 → count=0, flags clear, and the next read after refilling returns the new data.
